// File: rtl/simple_alu_pkg.sv
// Shared opcode encoding and status-flag bundle for the simple_alu datapath.
package simple_alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_NOT = 3'b100,
        OP_XOR = 3'b101,
        OP_SHL = 3'b110,
        OP_SHR = 3'b111
    } opcode_t;

    typedef struct packed {
        logic carry;
        logic zero;
        logic negative;
        logic overflow;
    } flags_t;

endpackage

// File: rtl/simple_alu_core.sv
// Combinational ALU core: next result and status flags from operands and opcode.
module simple_alu_core
    import simple_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  opcode_t          opcode,
    output logic [WIDTH-1:0] result,
    output flags_t           flags
);

    localparam int unsigned MSB = WIDTH - 1;

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    // One extra bit captures carry-out on add and borrow on subtract.
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        result         = '0;
        flags          = '0;
        case (opcode)
            OP_ADD: begin
                result         = sum[WIDTH-1:0];
                flags.carry    = sum[WIDTH];
                flags.overflow = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
            end
            OP_SUB: begin
                result         = diff[WIDTH-1:0];
                flags.carry    = diff[WIDTH];
                flags.overflow = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_NOT: result = ~a;
            OP_XOR: result = a ^ b;
            OP_SHL: begin
                result      = {a[WIDTH-2:0], 1'b0};
                flags.carry = a[MSB];
            end
            OP_SHR: begin
                result      = {1'b0, a[WIDTH-1:1]};
                flags.carry = a[0];
            end
            default: result = '0;
        endcase
        flags.zero     = (result == '0);
        flags.negative = result[MSB];
    end

endmodule

// File: rtl/simple_alu.sv
// Registered ALU wrapper: one-cycle latency, outputs hold while in_valid is low.
module simple_alu
    import simple_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       opcode,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             negative,
    output logic             overflow,
    output logic             out_valid
);

    logic [WIDTH-1:0] next_result;
    flags_t           next_flags;
    logic [WIDTH-1:0] result_q;
    flags_t           flags_q;
    logic             valid_q;

    simple_alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a      (A),
        .b      (B),
        .opcode (opcode_t'(opcode)),
        .result (next_result),
        .flags  (next_flags)
    );

    // Registers load only on in_valid, so X on idle inputs never reaches them.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            flags_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                result_q <= next_result;
                flags_q  <= next_flags;
            end
        end
    end

    assign result    = result_q;
    assign carry     = flags_q.carry;
    assign zero      = flags_q.zero;
    assign negative  = flags_q.negative;
    assign overflow  = flags_q.overflow;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_simple_alu.sv
// Directed-vector bench for simple_alu (WIDTH=4) with hand-computed expectations.
module tb_simple_alu;
    import simple_alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] A;
    logic [3:0] B;
    logic [2:0] opcode;
    logic [3:0] result;
    logic       carry;
    logic       zero;
    logic       negative;
    logic       overflow;
    logic       out_valid;

    int unsigned tests  = 0;
    int unsigned failed = 0;

    simple_alu #(
        .WIDTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .opcode    (opcode),
        .result    (result),
        .carry     (carry),
        .zero      (zero),
        .negative  (negative),
        .overflow  (overflow),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [3:0] r, input logic c,
                             input logic z, input logic n, input logic o, input logic v);
        check({tag, ".result"},    32'(result),    32'(r));
        check({tag, ".carry"},     32'(carry),     32'(c));
        check({tag, ".zero"},      32'(zero),      32'(z));
        check({tag, ".negative"},  32'(negative),  32'(n));
        check({tag, ".overflow"},  32'(overflow),  32'(o));
        check({tag, ".out_valid"}, 32'(out_valid), 32'(v));
    endtask

    // Drive one valid operation and step past the next rising edge.
    task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        in_valid = 1'b1;
        A        = a;
        B        = b;
        opcode   = op;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        A        = 'x;
        B        = 'x;
        opcode   = 'x;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b1;
        A        = 4'd5;
        B        = 4'd5;
        opcode   = OP_ADD;
        repeat (2) @(posedge clk);
        #1;
        check_out("reset", 4'h0, 0, 0, 0, 0, 0);
        rst = 1'b0;

        issue(4'd4, 4'd3, OP_ADD);       check_out("add_4_3",  4'h7, 0, 0, 0, 0, 1);
        issue(4'd7, 4'd2, OP_SUB);       check_out("sub_7_2",  4'h5, 0, 0, 0, 0, 1);
        issue(4'b1100, 4'b1010, OP_AND); check_out("and",      4'b1000, 0, 0, 1, 0, 1);
        issue(4'b1100, 4'b1010, OP_OR);  check_out("or",       4'b1110, 0, 0, 1, 0, 1);
        issue(4'b1100, 4'b1010, OP_NOT); check_out("not",      4'b0011, 0, 0, 0, 0, 1);
        issue(4'b1100, 4'b1010, OP_XOR); check_out("xor",      4'b0110, 0, 0, 0, 0, 1);

        issue(4'd15, 4'd1, OP_ADD);      check_out("add_wrap", 4'h0, 1, 1, 0, 0, 1);
        issue(4'd7, 4'd1, OP_ADD);       check_out("add_ovf",  4'h8, 0, 0, 1, 1, 1);
        issue(4'd2, 4'd3, OP_SUB);       check_out("sub_brw",  4'hF, 1, 0, 1, 0, 1);
        issue(4'd8, 4'd1, OP_SUB);       check_out("sub_ovf",  4'h7, 0, 0, 0, 1, 1);
        issue(4'd5, 4'd5, OP_SUB);       check_out("sub_zero", 4'h0, 0, 1, 0, 0, 1);

        issue(4'b1001, 4'b0000, OP_SHL); check_out("shl_1001", 4'b0010, 1, 0, 0, 0, 1);
        issue(4'b1001, 4'b1111, OP_SHR); check_out("shr_1001", 4'b0100, 1, 0, 0, 0, 1);
        issue(4'b0110, 4'b0000, OP_SHR); check_out("shr_0110", 4'b0011, 0, 0, 0, 0, 1);

        issue(4'd4, 4'd3, OP_ADD);       check_out("hold_op",  4'h7, 0, 0, 0, 0, 1);
        idle();                          check_out("hold_1",   4'h7, 0, 0, 0, 0, 0);
        idle();                          check_out("hold_2",   4'h7, 0, 0, 0, 0, 0);

        issue(4'd15, 4'd1, OP_ADD);      check_out("b2b_0",    4'h0, 1, 1, 0, 0, 1);
        issue(4'b1001, 4'd0, OP_SHL);    check_out("b2b_1",    4'b0010, 1, 0, 0, 0, 1);
        issue(4'd8, 4'd1, OP_SUB);       check_out("b2b_2",    4'h7, 0, 0, 0, 1, 1);

        issue(4'd7, 4'd1, OP_ADD);       check_out("pre_rst",  4'h8, 0, 0, 1, 1, 1);
        rst      = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        check_out("mid_rst", 4'h0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        issue(4'd4, 4'd3, OP_ADD);       check_out("post_rst", 4'h7, 0, 0, 0, 0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
